// File: rtl/eka_boot_loader.sv
// Boot loader for the Eka core: assembles a length-prefixed little-endian byte
// stream into 32-bit words, writes them to instruction memory, then releases core reset.
module eka_boot_loader #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            IMEM_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  im_wr_en,
  output logic [ADDR_WIDTH-1:0] im_wr_addr,
  output logic [31:0]           im_wr_data,
  output logic                  core_reset,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    LOAD,
    FLUSH,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  n_lo;
  logic [15:0] n_words;
  logic [15:0] hdr_n;
  logic [1:0]  byte_cnt;
  logic [23:0] word_acc;
  logic        xfer;
  logic        last_word;

  assign xfer      = rx_valid && rx_ready;
  assign hdr_n     = {rx_data, n_lo};
  // words_loaded increments on the same edge as the final byte, so compare ahead by one
  assign last_word = ({1'b0, words_loaded} + 17'd1) == {1'b0, n_words};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HDR_LO;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      HDR_LO: if (xfer) state_next = HDR_HI;
      HDR_HI: begin
        if (xfer) begin
          if (hdr_n == 16'd0) begin
            state_next = FLUSH;
          end else if (32'(hdr_n) > IMEM_WORDS) begin
            state_next = ERR;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD:   if (xfer && (byte_cnt == 2'd3) && last_word) state_next = FLUSH;
      FLUSH:  state_next = DONE;
      DONE:   state_next = DONE;
      ERR:    state_next = ERR;
      default: state_next = HDR_LO;
    endcase
  end

  always_comb begin
    rx_ready   = (state == HDR_LO) || (state == HDR_HI) || (state == LOAD);
    done       = (state == DONE);
    err        = (state == ERR);
    core_reset = (state != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_lo         <= '0;
      n_words      <= '0;
      byte_cnt     <= '0;
      word_acc     <= '0;
      im_wr_en     <= 1'b0;
      im_wr_addr   <= BASE_ADDR;
      im_wr_data   <= '0;
      words_loaded <= '0;
    end else begin
      im_wr_en <= 1'b0;
      if (xfer) begin
        case (state)
          HDR_LO: n_lo    <= rx_data;
          HDR_HI: n_words <= hdr_n;
          LOAD: begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              im_wr_en     <= 1'b1;
              im_wr_addr   <= BASE_ADDR + (ADDR_WIDTH'(words_loaded) << 2);
              im_wr_data   <= {rx_data, word_acc};
              words_loaded <= words_loaded + 16'd1;
            end else begin
              word_acc[8*byte_cnt +: 8] <= rx_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eka_boot_loader.sv
// Scoreboarded bench for eka_boot_loader: images are generated as word lists, the
// expected memory writes are queued up front and a negedge monitor retires them.
module tb_eka_boot_loader;

  localparam int unsigned IMEM = 16;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_wr_en;
  logic [31:0] im_wr_addr;
  logic [31:0] im_wr_data;
  logic        core_reset;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  eka_boot_loader #(
    .ADDR_WIDTH (32),
    .IMEM_WORDS (IMEM),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .im_wr_en     (im_wr_en),
    .im_wr_addr   (im_wr_addr),
    .im_wr_data   (im_wr_data),
    .core_reset   (core_reset),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] cnt;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (im_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h:%0h required=none", im_wr_addr, im_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", im_wr_addr, e.addr);
        check("wr_data", im_wr_data, e.data);
        check("wr_words_loaded", words_loaded, e.cnt);
        check("wr_core_reset", core_reset, 1);
      end
    end
  end

  task automatic do_reset();
    // a byte offered during reset must not be consumed
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h05;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_im_wr_en", im_wr_en, 0);
    check("rst_im_wr_addr", im_wr_addr, BASE);
    check("rst_im_wr_data", im_wr_data, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_words_loaded", words_loaded, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap_max);
    bit ok;
    int unsigned gap;
    gap      = $urandom_range(gap_max, 0);
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = rx_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic run_image(input logic [15:0] n, input int unsigned gap_max);
    logic [7:0]  byte_q[$];
    logic [31:0] w;
    bit          bad;
    bad = (32'(n) > IMEM);
    byte_q.push_back(n[7:0]);
    byte_q.push_back(n[15:8]);
    for (int i = 0; i < img.size(); i++) begin
      w = img[i];
      for (int b = 0; b < 4; b++) byte_q.push_back(w[8*b +: 8]);
    end
    if (!bad) begin
      for (int i = 0; i < int'(n); i++)
        exp_q.push_back('{addr: BASE + 32'(4 * i), data: img[i], cnt: 16'(i + 1)});
    end
    for (int i = 0; i < byte_q.size(); i++) send_byte(byte_q[i], gap_max);
    rx_valid = 1'b0;
    @(negedge clk);
    if (bad) begin
      check("err_flag", err, 1);
      check("err_rx_ready", rx_ready, 0);
      check("err_core_reset", core_reset, 1);
      check("err_done", done, 0);
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      repeat (8) @(posedge clk);
      #1;
      rx_valid = 1'b0;
      @(negedge clk);
      check("err_sticky", err, 1);
      check("err_core_reset_held", core_reset, 1);
      check("err_words_loaded", words_loaded, 0);
    end else begin
      check("flush_core_reset", core_reset, 1);
      check("flush_done", done, 0);
      check("flush_wr_en", im_wr_en, (n != 16'd0));
      @(negedge clk);
      check("done_core_reset", core_reset, 0);
      check("done_flag", done, 1);
      check("done_err", err, 0);
      check("done_rx_ready", rx_ready, 0);
      check("done_words_loaded", words_loaded, n);
    end
    check("pending_writes", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;

    do_reset();
    img = '{32'h0000_0013, 32'h0010_0093};
    run_image(16'd2, 0);

    do_reset();
    img.delete();
    run_image(16'd0, 0);

    do_reset();
    run_image(16'(IMEM + 1), 0);
    do_reset();
    run_image(16'hFFFF, 2);

    do_reset();
    img = '{32'h0000_0013, 32'h0010_0093};
    run_image(16'd2, 5);

    // partial word then reset: no write may appear
    do_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();
    run_image(16'd2, 1);

    do_reset();
    img.delete();
    for (int i = 0; i < int'(IMEM); i++) img.push_back($urandom);
    run_image(16'(IMEM), 3);

    repeat (6) begin
      int unsigned n;
      do_reset();
      n = $urandom_range(IMEM, 1);
      img.delete();
      for (int i = 0; i < int'(n); i++) img.push_back($urandom);
      run_image(16'(n), $urandom_range(3, 0));
    end

    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
